// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the single-cycle core.
// Owns the fetch PC, issues word requests over req/gnt/rvalid, buffers the
// returned words in a small FIFO and hands {instr, pc} to the core.
// Optional build macro FETCH_PERF_CNT_EN adds three 32-bit perf counters.
//
// Handshakes: memory request is accepted on a cycle where mem_req_o and
// mem_gnt_i are both 1; mem_addr_o is held while req is up without gnt
// (a redirect may withdraw it). The core consumes the head on a cycle where
// instr_valid_o and instr_ready_i are both 1; instr_o/instr_pc_o are stable
// while valid is up and not consumed, except that a redirect flushes them.
module fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched_o,
  output logic [31:0]       perf_flushed_o,
  output logic [31:0]       perf_starve_o,
`endif
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  // Outstanding/discard counters need headroom above FIFO_DEPTH: after a
  // redirect the words still in flight are counted as discards while new
  // requests are issued against fresh credit.
  localparam int CNT_W = PTR_W + 4;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [31:0]       fifo_instr_q [FIFO_DEPTH];
  logic [31:0]       fifo_instr_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  // Pending-PC queue holds only live (non-discarded) requests.
  logic [ADDR_W-1:0] pend_pc_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pend_pc_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;

  logic [CNT_W-1:0]  live_cnt;
  logic              mem_grant;
  logic              fifo_push;
  logic              fifo_pop;
  logic              rsp_drop;

  // Credit check, handshake qualifiers and head-of-FIFO outputs
  always_comb begin
    live_cnt      = outstanding_q - discard_q + CNT_W'(fifo_cnt_q);
    mem_req_o     = !reset_i && !redirect_i && (live_cnt < CNT_W'(FIFO_DEPTH));
    mem_addr_o    = fetch_pc_q;
    mem_grant     = mem_req_o && mem_gnt_i;
    instr_valid_o = (fifo_cnt_q != '0);
    instr_o       = instr_valid_o ? fifo_instr_q[fifo_rd_q] : 32'd0;
    instr_pc_o    = instr_valid_o ? fifo_pc_q[fifo_rd_q] : '0;
    fifo_push     = mem_rvalid_i && !redirect_i && (discard_q == '0);
    fifo_pop      = instr_valid_o && instr_ready_i && !redirect_i;
    rsp_drop      = mem_rvalid_i && !fifo_push;
  end

  // Next-state: redirect flushes everything; otherwise track grants/returns
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q - CNT_W'(mem_rvalid_i);
    discard_d     = discard_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_cnt_d    = fifo_cnt_q;
    pend_pc_d     = pend_pc_q;
    pend_wr_d     = pend_wr_q;
    pend_rd_d     = pend_rd_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~ADDR_W'(3);
      discard_d  = outstanding_d;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      pend_wr_d  = '0;
      pend_rd_d  = '0;
    end else begin
      if (mem_grant) begin
        pend_pc_d[pend_wr_q] = fetch_pc_q;
        pend_wr_d            = pend_wr_q + 1'b1;
        fetch_pc_d           = fetch_pc_q + ADDR_W'(4);
        outstanding_d        = outstanding_d + CNT_W'(1);
      end
      if (mem_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (fifo_push) begin
        fifo_instr_d[fifo_wr_q] = mem_rdata_i;
        fifo_pc_d[fifo_wr_q]    = pend_pc_q[pend_rd_q];
        fifo_wr_d               = fifo_wr_q + 1'b1;
        pend_rd_d               = pend_rd_q + 1'b1;
      end
      if (fifo_pop) begin
        fifo_rd_d = fifo_rd_q + 1'b1;
      end
      fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_instr_q  <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_cnt_q    <= '0;
      pend_pc_q     <= '{default: '0};
      pend_wr_q     <= '0;
      pend_rd_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_cnt_q    <= fifo_cnt_d;
      pend_pc_q     <= pend_pc_d;
      pend_wr_q     <= pend_wr_d;
      pend_rd_q     <= pend_rd_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [31:0] perf_starve_q, perf_starve_d;

  // Perf counters: delivered words, thrown-away work, starved core cycles
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(fifo_push);
    perf_flushed_d = perf_flushed_q + 32'(rsp_drop)
                   + (redirect_i ? 32'(fifo_cnt_q) : 32'd0);
    perf_starve_d  = perf_starve_q + 32'(instr_ready_i && !instr_valid_o);
  end

  // Perf counter registers
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
      perf_starve_q  <= perf_starve_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_flushed_o = perf_flushed_q;
  assign perf_starve_o  = perf_starve_q;
`else
  logic unused_drop;
  assign unused_drop = rsp_drop;
`endif

`ifndef SYNTHESIS
  a_rvalid_without_request: assert property (@(posedge clk) disable iff (reset_i)
    !(mem_rvalid_i && (outstanding_q == '0)));
  a_fifo_overflow: assert property (@(posedge clk) disable iff (reset_i)
    !(fifo_push && !fifo_pop && (fifo_cnt_q == CW'(FIFO_DEPTH))));
`endif

endmodule
